// File: rtl/cpu_ctrl_fsm.sv
// ============================================================================
// cpu_ctrl_fsm : multicycle Moore control unit for the 16-bit CPU datapath.
// Optional feature macro: CTRL_ILLEGAL_HALT_EN (illegal opcodes halt the core).
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_on,
    input  logic [15:0] instr,
    input  logic        n_flag,
    input  logic        z_flag,
    input  logic        c_flag,
    input  logic        v_flag,
    output logic [1:0]  alu_ctrl,
    output logic [1:0]  alu_srcb,
    output logic [1:0]  pc_jp,
    output logic        e_pc,
    output logic        rst_pc,
    output logic        IorD,
    output logic        we_mem,
    output logic        we_ir,
    output logic        mixMR,
    output logic        MtoR,
    output logic        rd_read,
    output logic        PCtoR,
    output logic        we_reg,
    output logic        alu_srca,
    output logic        e_flag,
    output logic        pc_src,
    output logic        e_out_r,
    output logic        halted
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_EXEC    = 4'd3;
    localparam logic [3:0] S_ALU_WB  = 4'd4;
    localparam logic [3:0] S_IMM_WB  = 4'd5;
    localparam logic [3:0] S_ADDR    = 4'd6;
    localparam logic [3:0] S_MEM_RD  = 4'd7;
    localparam logic [3:0] S_LD_WB   = 4'd8;
    localparam logic [3:0] S_ST_HOLD = 4'd9;
    localparam logic [3:0] S_MEM_WR  = 4'd10;
    localparam logic [3:0] S_OUT     = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;
    localparam logic [3:0] S_BRANCH  = 4'd13;
    localparam logic [3:0] S_HALT    = 4'd14;

    localparam logic [4:0] C_OP_LHI  = 5'b00110;
    localparam logic [4:0] C_OP_ST   = 5'b01000;
    localparam logic [4:0] C_OP_JR   = 5'b01010;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [4:0] w_op;
    logic [3:0] w_fetch_next;
    logic       w_br_taken;
    logic       w_unused;

    assign w_op     = instr[15:11];
    assign w_unused = ^{v_flag, instr[10:0]};

    // Every path back to FETCH re-samples cpu_on so a stop request lands in IDLE.
    assign w_fetch_next = cpu_on ? S_FETCH : S_IDLE;

    always_comb begin
        w_br_taken = 1'b0;
        case (w_op[1:0])
            2'b00:   w_br_taken = z_flag;
            2'b01:   w_br_taken = ~z_flag;
            2'b10:   w_br_taken = n_flag;
            default: w_br_taken = c_flag;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = cpu_on ? S_FETCH : S_IDLE;
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                casez (w_op)
                    5'b00000:                       state_d = w_fetch_next;
                    5'b00001, 5'b00010,
                    5'b00011, 5'b00100:             state_d = S_EXEC;
                    5'b00101, 5'b00110:             state_d = S_IMM_WB;
                    5'b00111, 5'b01000:             state_d = S_ADDR;
                    5'b01001:                       state_d = S_OUT;
                    5'b01010, 5'b111??:             state_d = S_JUMP;
                    5'b011??:                       state_d = S_BRANCH;
                    5'b11011:                       state_d = S_HALT;
`ifdef CTRL_ILLEGAL_HALT_EN
                    default:                        state_d = S_HALT;
`else
                    default:                        state_d = w_fetch_next;
`endif
                endcase
            end
            S_EXEC:    state_d = S_ALU_WB;
            S_ADDR:    state_d = (w_op == C_OP_ST) ? S_ST_HOLD : S_MEM_RD;
            S_MEM_RD:  state_d = S_LD_WB;
            S_ST_HOLD: state_d = S_MEM_WR;
            S_HALT:    state_d = S_HALT;
            S_ALU_WB, S_IMM_WB, S_LD_WB, S_MEM_WR,
            S_OUT, S_JUMP, S_BRANCH:
                       state_d = w_fetch_next;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        alu_ctrl = 2'b00;
        alu_srcb = 2'b00;
        pc_jp    = 2'b00;
        e_pc     = 1'b0;
        rst_pc   = 1'b0;
        IorD     = 1'b0;
        we_mem   = 1'b0;
        we_ir    = 1'b0;
        mixMR    = 1'b0;
        MtoR     = 1'b0;
        rd_read  = 1'b0;
        PCtoR    = 1'b0;
        we_reg   = 1'b0;
        alu_srca = 1'b0;
        e_flag   = 1'b0;
        pc_src   = 1'b0;
        e_out_r  = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_IDLE:   rst_pc = 1'b1;
            S_FETCH: begin
                we_ir    = 1'b1;
                alu_srcb = 2'b01;
                e_pc     = 1'b1;
            end
            S_DECODE: alu_srcb = 2'b11;
            S_EXEC: begin
                // ADD..OR opcodes are 1..4, so op-1 yields the ALU encoding.
                alu_ctrl = w_op[1:0] - 2'd1;
                alu_srca = 1'b1;
                e_flag   = 1'b1;
            end
            S_ALU_WB: we_reg = 1'b1;
            S_IMM_WB: begin
                we_reg  = 1'b1;
                mixMR   = 1'b1;
                MtoR    = (w_op == C_OP_LHI);
                rd_read = (w_op == C_OP_LHI);
            end
            S_ADDR: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
            end
            S_MEM_RD: IorD = 1'b1;
            S_LD_WB: begin
                we_reg = 1'b1;
                MtoR   = 1'b1;
            end
            S_ST_HOLD: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
                rd_read  = 1'b1;
            end
            S_MEM_WR: begin
                IorD    = 1'b1;
                we_mem  = 1'b1;
                rd_read = 1'b1;
            end
            S_OUT:    e_out_r = 1'b1;
            S_JUMP: begin
                e_pc  = 1'b1;
                pc_jp = (w_op == C_OP_JR) ? 2'b10 : 2'b01;
            end
            S_BRANCH: begin
                pc_src = 1'b1;
                e_pc   = w_br_taken;
            end
            S_HALT:   halted = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
// ============================================================================
// tb_cpu_ctrl_fsm : scoreboard bench, directed instruction sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_on;
    logic [15:0] instr;
    logic        n_flag, z_flag, c_flag, v_flag;
    logic [1:0]  alu_ctrl, alu_srcb, pc_jp;
    logic        e_pc, rst_pc, IorD, we_mem, we_ir, mixMR, MtoR, rd_read;
    logic        PCtoR, we_reg, alu_srca, e_flag, pc_src, e_out_r, halted;

    always #5 clk = ~clk;

    cpu_ctrl_fsm dut (
        .clk(clk), .rst(rst), .cpu_on(cpu_on), .instr(instr),
        .n_flag(n_flag), .z_flag(z_flag), .c_flag(c_flag), .v_flag(v_flag),
        .alu_ctrl(alu_ctrl), .alu_srcb(alu_srcb), .pc_jp(pc_jp),
        .e_pc(e_pc), .rst_pc(rst_pc), .IorD(IorD), .we_mem(we_mem),
        .we_ir(we_ir), .mixMR(mixMR), .MtoR(MtoR), .rd_read(rd_read),
        .PCtoR(PCtoR), .we_reg(we_reg), .alu_srca(alu_srca), .e_flag(e_flag),
        .pc_src(pc_src), .e_out_r(e_out_r), .halted(halted)
    );

    // Control word: {alu_ctrl, alu_srcb, pc_jp, e_pc, rst_pc, IorD, we_mem, we_ir,
    //                mixMR, MtoR, rd_read, PCtoR, we_reg, alu_srca, e_flag, pc_src, e_out_r, halted}
    localparam logic [20:0] B_EPC    = 21'd1 << 14;
    localparam logic [20:0] B_RSTPC  = 21'd1 << 13;
    localparam logic [20:0] B_IORD   = 21'd1 << 12;
    localparam logic [20:0] B_WEMEM  = 21'd1 << 11;
    localparam logic [20:0] B_WEIR   = 21'd1 << 10;
    localparam logic [20:0] B_MIXMR  = 21'd1 << 9;
    localparam logic [20:0] B_MTOR   = 21'd1 << 8;
    localparam logic [20:0] B_RDREAD = 21'd1 << 7;
    localparam logic [20:0] B_WEREG  = 21'd1 << 5;
    localparam logic [20:0] B_SRCA   = 21'd1 << 4;
    localparam logic [20:0] B_EFLAG  = 21'd1 << 3;
    localparam logic [20:0] B_PCSRC  = 21'd1 << 2;
    localparam logic [20:0] B_EOUT   = 21'd1 << 1;
    localparam logic [20:0] B_HALTED = 21'd1;

    localparam logic [20:0] X_IDLE    = B_RSTPC;
    localparam logic [20:0] X_FETCH   = B_WEIR | B_EPC | (21'd1 << 17);
    localparam logic [20:0] X_DECODE  = 21'd3 << 17;
    localparam logic [20:0] X_ALU_WB  = B_WEREG;
    localparam logic [20:0] X_LDI_WB  = B_WEREG | B_MIXMR;
    localparam logic [20:0] X_LHI_WB  = B_WEREG | B_MIXMR | B_MTOR | B_RDREAD;
    localparam logic [20:0] X_ADDR    = B_SRCA | (21'd2 << 17);
    localparam logic [20:0] X_ST_HOLD = B_SRCA | (21'd2 << 17) | B_RDREAD;
    localparam logic [20:0] X_MEM_WR  = B_IORD | B_WEMEM | B_RDREAD;
    localparam logic [20:0] X_MEM_RD  = B_IORD;
    localparam logic [20:0] X_LD_WB   = B_WEREG | B_MTOR;
    localparam logic [20:0] X_OUT     = B_EOUT;
    localparam logic [20:0] X_JR      = B_EPC | (21'd2 << 15);
    localparam logic [20:0] X_JMP     = B_EPC | (21'd1 << 15);
    localparam logic [20:0] X_BR_NT   = B_PCSRC;
    localparam logic [20:0] X_BR_T    = B_PCSRC | B_EPC;
    localparam logic [20:0] X_HALT    = B_HALTED;

    function automatic logic [20:0] x_exec(input logic [1:0] ctrl);
        return ({19'd0, ctrl} << 19) | B_SRCA | B_EFLAG;
    endfunction

    logic [20:0] exp_q[$];
    string       tag_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    wire [20:0] w_got = {alu_ctrl, alu_srcb, pc_jp, e_pc, rst_pc, IorD, we_mem, we_ir,
                         mixMR, MtoR, rd_read, PCtoR, we_reg, alu_srca, e_flag,
                         pc_src, e_out_r, halted};

    // Monitor: the DUT presents a control word every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [20:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_total++;
            if (w_got === e) n_pass++;
            else $display("FAIL %s: got %06h expected %06h", t, w_got, e);
        end
    end

    task automatic step(input string t, input logic [20:0] e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        #1;
    endtask

    task automatic fd(input string t, input logic [15:0] iw);
        instr = iw;
        step({t, "_fetch"},  X_FETCH);
        step({t, "_decode"}, X_DECODE);
    endtask

    initial begin
        rst = 1'b1; cpu_on = 1'b1; instr = 16'h0000;
        n_flag = 1'b0; z_flag = 1'b0; c_flag = 1'b0; v_flag = 1'b0;

        step("reset", X_IDLE);
        rst = 1'b0;

        fd("add", 16'h0900); step("add_exec", x_exec(2'b00)); step("add_wb", X_ALU_WB);
        fd("sub", 16'h1000); step("sub_exec", x_exec(2'b01)); step("sub_wb", X_ALU_WB);
        fd("and", 16'h1800); step("and_exec", x_exec(2'b10)); step("and_wb", X_ALU_WB);
        fd("or",  16'h2000); step("or_exec",  x_exec(2'b11)); step("or_wb",  X_ALU_WB);
        fd("ldi", 16'h2812); step("ldi_wb", X_LDI_WB);
        fd("lhi", 16'h3034); step("lhi_wb", X_LHI_WB);
        fd("st",  16'h4000); step("st_addr", X_ADDR); step("st_hold", X_ST_HOLD);
        step("st_memwr", X_MEM_WR);
        fd("ld",  16'h3800); step("ld_addr", X_ADDR); step("ld_memrd", X_MEM_RD);
        step("ld_wb", X_LD_WB);
        fd("out", 16'h4800); step("out", X_OUT);
        fd("jr",  16'h5000); step("jr", X_JR);
        fd("jmp", 16'hE123); step("jmp", X_JMP);

        z_flag = 1'b0; fd("bz0", 16'h6000); step("bz_z0", X_BR_NT);
        z_flag = 1'b1; fd("bz1", 16'h6000); step("bz_z1", X_BR_T);
        fd("bnz", 16'h6800); step("bnz_z1", X_BR_NT);
        n_flag = 1'b1; fd("bn", 16'h7000); step("bn_n1", X_BR_T);
        c_flag = 1'b0; fd("bc", 16'h7800); step("bc_c0", X_BR_NT);

        fd("illegal", 16'h8000);
`ifdef CTRL_ILLEGAL_HALT_EN
        step("illegal_halt", X_HALT);
        rst = 1'b1;
        step("illegal_reset", X_IDLE);
        rst = 1'b0;
`endif
        fd("nop", 16'h0000);
        cpu_on = 1'b0;
        step("stop_idle", X_IDLE);
        step("stop_idle2", X_IDLE);
        cpu_on = 1'b1;

        fd("ld_abort", 16'h3800); step("ld_abort_addr", X_ADDR);
        rst = 1'b1;
        step("ld_abort_reset", X_IDLE);
        rst = 1'b0;
        step("after_abort_fetch", X_FETCH);
        step("after_abort_decode", X_DECODE);
        step("after_abort_addr", X_ADDR);
        step("after_abort_memrd", X_MEM_RD);
        step("after_abort_wb", X_LD_WB);

        fd("halt", 16'hD800);
        step("halt1", X_HALT); step("halt2", X_HALT); step("halt3", X_HALT);
        rst = 1'b1;
        step("halt_reset", X_IDLE);
        rst = 1'b0;

        @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
